// File: rtl/alu_frame_sequencer.sv
// Byte-serial front end for the combinational ALU: collects operand A, operand B
// and an op code from the RX core, runs one execute cycle, then returns the result
// byte and a status byte through the TX core.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   WAIT_A   | idle, waiting for operand A (only non-busy state)
//   WAIT_B   | waiting for operand B, inter-byte timeout running
//   WAIT_OP  | waiting for op code, inter-byte timeout running
//   EXEC     | ALU inputs settled, capture result and status
//   SEND_RES | result byte handed to TX (o_tx_start high here)
//   WAIT_RES | waiting for TX to finish the result byte
//   SEND_STS | status byte loaded, start pulse issued next cycle
//   WAIT_STS | waiting for TX to finish the status byte
module alu_frame_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP_CODE     = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic [NB_DATA-1:0]    o_alu_data_a,
  output logic [NB_DATA-1:0]    o_alu_data_b,
  output logic [NB_OP_CODE-1:0] o_alu_op_code,
  input  logic [NB_DATA-1:0]    i_alu_result,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_carry,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_overrun
);

  localparam int NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_TC = NB_CNT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_STS, WAIT_STS
  } state_t;

  state_t              state, state_next;
  logic [NB_CNT-1:0]   tmo_cnt;
  logic [NB_DATA-1:0]  status_q;
  logic                accept;
  logic                timeout_hit;
  logic                rx_blocked;
  logic                cnt_run;
  logic                op_valid;

  assign o_busy     = (state != WAIT_A);
  assign rx_blocked = (state != WAIT_A) && (state != WAIT_B) && (state != WAIT_OP);
  assign cnt_run    = (state == WAIT_B) || (state == WAIT_OP);

  // Decode the registered op code against the ALU's supported operations.
  always_comb begin
    op_valid = 1'b0;
    case (o_alu_op_code)
      NB_OP_CODE'(6'b100000), NB_OP_CODE'(6'b100010), NB_OP_CODE'(6'b100100),
      NB_OP_CODE'(6'b100101), NB_OP_CODE'(6'b100110), NB_OP_CODE'(6'b000011),
      NB_OP_CODE'(6'b000010), NB_OP_CODE'(6'b100111): op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  // Next-state logic; a byte arriving on the terminal-count cycle beats the timeout.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      WAIT_A: if (i_rx_done) begin
        accept     = 1'b1;
        state_next = WAIT_B;
      end
      WAIT_B: if (i_rx_done) begin
        accept     = 1'b1;
        state_next = WAIT_OP;
      end else if (tmo_cnt == CNT_TC) begin
        timeout_hit = 1'b1;
        state_next  = WAIT_A;
      end
      WAIT_OP: if (i_rx_done) begin
        accept     = 1'b1;
        state_next = EXEC;
      end else if (tmo_cnt == CNT_TC) begin
        timeout_hit = 1'b1;
        state_next  = WAIT_A;
      end
      EXEC:     state_next = SEND_RES;
      SEND_RES: state_next = WAIT_RES;
      WAIT_RES: if (i_tx_done && !o_tx_start) state_next = SEND_STS;
      SEND_STS: state_next = WAIT_STS;
      WAIT_STS: if (i_tx_done && !o_tx_start) state_next = WAIT_A;
      default:  state_next = WAIT_A;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= WAIT_A;
    else         state <= state_next;
  end

  // Inter-byte timer: counts idle cycles inside a partial frame, cleared otherwise.
  always_ff @(posedge i_clock) begin
    if (i_reset || !cnt_run || accept || timeout_hit) tmo_cnt <= '0;
    else                                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  // ALU operand/op-code registers, loaded only on the accepting edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu_data_a  <= '0;
      o_alu_data_b  <= '0;
      o_alu_op_code <= '0;
    end else if (accept) begin
      case (state)
        WAIT_A:  o_alu_data_a  <= i_rx_data;
        WAIT_B:  o_alu_data_b  <= i_rx_data;
        default: o_alu_op_code <= i_rx_data[NB_OP_CODE-1:0];
      endcase
    end
  end

  // TX side: the start pulse is registered, so the byte is loaded on the same edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      status_q   <= '0;
    end else begin
      o_tx_start <= (state == EXEC) || (state == SEND_STS);
      if (state == EXEC) begin
        o_tx_data <= op_valid ? i_alu_result : '0;
        status_q  <= op_valid ? NB_DATA'({i_alu_carry, i_alu_zero})
                              : {1'b1, {(NB_DATA-1){1'b0}}};
      end else if (state == SEND_STS) begin
        o_tx_data <= status_q;
      end
    end
  end

  // Timeout pulse and sticky overrun flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
      if (i_rx_done && rx_blocked) o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed bench: ALU behavioural model, auto-responding TX core, table of frames
// plus hand-written timeout, overrun and reset sequences.
module tb_alu_frame_sequencer;

  localparam int TMO = 16;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic [7:0] o_alu_data_a, o_alu_data_b;
  logic [5:0] o_alu_op_code;
  logic [7:0] i_alu_result;
  logic       i_alu_zero, i_alu_carry;
  logic       o_busy, o_timeout, o_overrun;

  alu_frame_sequencer #(.NB_DATA(8), .NB_OP_CODE(6), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_alu_data_a(o_alu_data_a), .o_alu_data_b(o_alu_data_b), .o_alu_op_code(o_alu_op_code),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_alu_carry(i_alu_carry),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int done_cyc = 0;
  int n_start = 0;
  int n_timeout = 0;
  int to_cyc = 0;
  bit alu_force = 1'b0;
  logic [7:0] tx_q[$];
  int         sc_q[$];

  // Reference ALU; alu_force substitutes garbage to prove invalid ops ignore it.
  always_comb begin
    i_alu_result = 8'h00;
    i_alu_carry  = 1'b0;
    case (o_alu_op_code)
      6'h20: {i_alu_carry, i_alu_result} = {1'b0, o_alu_data_a} + {1'b0, o_alu_data_b};
      6'h22: begin
        i_alu_result = o_alu_data_a - o_alu_data_b;
        i_alu_carry  = (o_alu_data_a >= o_alu_data_b);
      end
      6'h24: i_alu_result = o_alu_data_a & o_alu_data_b;
      6'h25: i_alu_result = o_alu_data_a | o_alu_data_b;
      6'h26: i_alu_result = o_alu_data_a ^ o_alu_data_b;
      6'h27: i_alu_result = ~(o_alu_data_a | o_alu_data_b);
      6'h03: i_alu_result = $unsigned($signed(o_alu_data_a) >>> o_alu_data_b);
      6'h02: i_alu_result = o_alu_data_a >> o_alu_data_b;
      default: i_alu_result = 8'h00;
    endcase
    i_alu_zero = (i_alu_result == 8'h00);
    if (alu_force) begin
      i_alu_result = 8'hA5;
      i_alu_zero   = 1'b1;
      i_alu_carry  = 1'b1;
    end
  end

  // TX core model and event monitor, sampling 1 time unit after each rising edge.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      cyc++;
      i_tx_done = 1'b0;
      if (i_reset) tx_cnt = 0;
      else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_tx_done = 1'b1;
          done_cyc  = cyc;
        end
      end
      if (o_tx_start) begin
        n_start++;
        tx_q.push_back(o_tx_data);
        sc_q.push_back(cyc);
        tx_cnt = 10;
      end
      if (o_timeout) begin
        n_timeout++;
        to_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] er, input logic [7:0] es, input bit frc,
                           input int gap, input bit inj, input string nm);
    int op_cyc;
    int w;
    alu_force = frc;
    tx_q.delete();
    sc_q.delete();
    send_byte(a);
    repeat (gap) step();
    send_byte(b);
    op_cyc = cyc;
    send_byte(op);
    if (inj) begin
      w = 0;
      while (tx_q.size() < 1 && w < 50) begin step(); w++; end
      repeat (3) step();
      send_byte(8'h55);
      chk({nm, " overrun set"}, int'(o_overrun), 1);
    end
    w = 0;
    while (!(tx_q.size() == 2 && !o_busy) && w < 200) begin step(); w++; end
    chk({nm, " byte count"}, tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      chk({nm, " result"}, int'(tx_q[0]), int'(er));
      chk({nm, " status"}, int'(tx_q[1]), int'(es));
      chk({nm, " start latency"}, sc_q[0] - op_cyc, 2);
      chk({nm, " status latency"}, sc_q[1] - sc_q[0], 12);
      chk({nm, " release"}, cyc - done_cyc, 1);
    end
    chk({nm, " alu a"}, int'(o_alu_data_a), int'(a));
    chk({nm, " alu b"}, int'(o_alu_data_b), int'(b));
    chk({nm, " alu op"}, int'(o_alu_op_code), int'(op[5:0]));
    alu_force = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b, op, res, sts;
    bit         frc;
    int         gap;
    string      nm;
  } vec_t;

  vec_t vecs[12];
  int   n0, nt0, ns0, w;

  initial begin
    vecs[0]  = '{8'hF0, 8'h20, 8'h20, 8'h10, 8'h02, 1'b0, 0,  "add carry"};
    vecs[1]  = '{8'h05, 8'h05, 8'h22, 8'h00, 8'h03, 1'b0, 0,  "sub zero"};
    vecs[2]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 8'h00, 1'b0, 0,  "sub borrow"};
    vecs[3]  = '{8'h12, 8'h34, 8'h3F, 8'h00, 8'h80, 1'b1, 0,  "invalid 3f"};
    vecs[4]  = '{8'h0F, 8'h3C, 8'h24, 8'h0C, 8'h00, 1'b0, 0,  "and"};
    vecs[5]  = '{8'h0F, 8'h30, 8'h25, 8'h3F, 8'h00, 1'b0, 0,  "or"};
    vecs[6]  = '{8'hFF, 8'hFF, 8'h26, 8'h00, 8'h01, 1'b0, 0,  "xor zero"};
    vecs[7]  = '{8'h80, 8'h03, 8'h02, 8'h10, 8'h00, 1'b0, 0,  "srl"};
    vecs[8]  = '{8'h00, 8'h00, 8'h27, 8'hFF, 8'h00, 1'b0, 0,  "nor"};
    vecs[9]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 1'b0, 0,  "add wrap"};
    vecs[10] = '{8'h01, 8'h01, 8'hE0, 8'h02, 8'h00, 1'b0, 0,  "op high bits"};
    vecs[11] = '{8'h09, 8'h0A, 8'h21, 8'h00, 8'h80, 1'b1, 15, "late byte wins"};

    i_reset   = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    repeat (3) step();
    i_reset = 1'b0;
    chk("reset tx_start", int'(o_tx_start), 0);
    chk("reset tx_data", int'(o_tx_data), 0);
    chk("reset busy", int'(o_busy), 0);
    chk("reset timeout", int'(o_timeout), 0);
    chk("reset overrun", int'(o_overrun), 0);
    chk("reset alu a", int'(o_alu_data_a), 0);
    chk("reset alu b", int'(o_alu_data_b), 0);
    chk("reset alu op", int'(o_alu_op_code), 0);

    for (int i = 0; i < 12; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].sts,
                vecs[i].frc, vecs[i].gap, 1'b0, vecs[i].nm);
    chk("no timeout on late byte", n_timeout, 0);
    chk("no overrun in clean frames", int'(o_overrun), 0);

    // Partial frame abandoned: A accepted, then TMO idle cycles.
    n0 = cyc;
    nt0 = n_timeout;
    send_byte(8'h07);
    repeat (TMO + 10) step();
    chk("timeout pulses", n_timeout - nt0, 1);
    chk("timeout cycle", to_cyc - n0, TMO + 1);
    chk("timeout idle", int'(o_busy), 0);
    run_frame(8'h01, 8'h02, 8'h20, 8'h03, 8'h00, 1'b0, 0, 1'b0, "after timeout");

    // Byte dropped while waiting for TX: response unaffected, flag sticky.
    run_frame(8'h11, 8'h22, 8'h20, 8'h33, 8'h00, 1'b0, 0, 1'b1, "overrun frame");
    chk("overrun sticky", int'(o_overrun), 1);

    // Reset while the result byte is in flight.
    tx_q.delete();
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h20);
    w = 0;
    while (tx_q.size() < 1 && w < 50) begin step(); w++; end
    chk("pre-reset start seen", tx_q.size(), 1);
    repeat (3) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("midreset busy", int'(o_busy), 0);
    chk("midreset tx_data", int'(o_tx_data), 0);
    chk("midreset tx_start", int'(o_tx_start), 0);
    chk("midreset overrun", int'(o_overrun), 0);
    chk("midreset alu a", int'(o_alu_data_a), 0);
    ns0 = n_start;
    repeat (30) step();
    chk("no start after reset", n_start - ns0, 0);
    run_frame(8'h80, 8'h01, 8'h03, 8'hC0, 8'h00, 1'b0, 0, 1'b0, "sra after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_frame_sequencer.md
# alu_frame_sequencer

Sequences the combinational ALU from a byte-serial link (UART RX/TX cores). Assembles three received bytes (operand A, operand B, op code) into one operation and drives the ALU operand/op-code inputs from registers. After one execute cycle it captures the result and flags and returns two bytes to the TX core: the result, then a status byte. Sits between the UART RX/TX cores and the ALU in the top-level.

## Interface
Parameters:
- NB_DATA, 8, ALU data width and link byte width (the status-byte layout below fixes it at 8)
- NB_OP_CODE, 6, ALU op-code width; taken from the low bits of the op byte
- TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one frame; must be ≥ 2

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  synchronous reset, active-high
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, byte received
- o_tx_data  out  NB_DATA  byte to transmit, held stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle pulse, start transmission
- i_tx_done  in  1  one-cycle pulse, TX core finished the byte
- o_alu_data_a  out  NB_DATA  ALU operand A (registered)
- o_alu_data_b  out  NB_DATA  ALU operand B (registered)
- o_alu_op_code  out  NB_OP_CODE  ALU op code (registered)
- i_alu_result  in  NB_DATA  ALU result
- i_alu_zero  in  1  ALU zero flag
- i_alu_carry  in  1  ALU carry flag (ADD carry-out; SUB no-borrow)
- o_busy  out  1  high in every state except WAIT_A
- o_timeout  out  1  one-cycle pulse, partial frame discarded
- o_overrun  out  1  sticky, byte received while not accepting; cleared only by reset

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_STS, WAIT_STS.
- WAIT_A: on i_rx_done, load o_alu_data_a ← i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_done, load o_alu_data_b; go to WAIT_OP.
- WAIT_OP: on i_rx_done, load o_alu_op_code ← i_rx_data[NB_OP_CODE-1:0]; go to EXEC.
- Valid op codes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111. Any other code is invalid.
- EXEC: capture the result and the status byte internally; go to SEND_RES.
  - Valid op: result = i_alu_result; status = {1'b0, 5'b0, i_alu_carry, i_alu_zero}.
  - Invalid op: result = 8'h00; status = 8'h80. ALU outputs are ignored.
- SEND_RES: o_tx_start=1 for one cycle, o_tx_data = result; go to WAIT_RES.
- WAIT_RES: on i_tx_done, go to SEND_STS.
- SEND_STS: o_tx_start=1 for one cycle, o_tx_data = status; go to WAIT_STS.
- WAIT_STS: on i_tx_done, go to WAIT_A.
- Timeout counter:
  - Runs only in WAIT_B and WAIT_OP.
  - Cleared on every accepted byte and on entry to WAIT_A.
  - If it reaches TIMEOUT_CYCLES-1 with no i_rx_done, the frame is discarded: go to WAIT_A and pulse o_timeout for one cycle.
  - A byte arriving in that same cycle wins: it is accepted and no timeout occurs.
- i_rx_done in EXEC, SEND_*, or WAIT_*S states: byte dropped, o_overrun set.
- i_tx_done outside WAIT_RES/WAIT_STS is ignored, including when it coincides with o_tx_start.

## Timing
- Reset values: state WAIT_A; o_alu_data_a/b = 0; o_alu_op_code = 0; o_tx_data = 0; o_tx_start = 0; o_busy = 0; o_timeout = 0; o_overrun = 0; timeout counter = 0.
- Reset mid-frame or mid-transmission: the next edge returns everything to reset values; no further o_tx_start.
- ALU inputs change only on the edge that accepts the corresponding byte and stay stable until the next frame loads them.
- Latency, op byte at cycle N (i_rx_done high):
  - N+1: EXEC.
  - N+2: o_tx_start with the result byte.
  - Status byte: o_tx_start 2 cycles after the i_tx_done cycle.
- o_tx_data holds its value until the next o_tx_start or reset.
- Back-to-back frames: the first byte of the next frame is accepted in the cycle after the final i_tx_done.

## Test plan
- Frame F0,20,ADD; i_tx_done 10 cycles after each start → TX bytes 10 then 02; o_tx_start exactly 2 cycles after the op-byte pulse.
- Frame 05,05,SUB → TX bytes 00, 03 (zero + no-borrow). Frame 03,05,SUB → FE, 00.
- Frame 12,34,op 3F → TX bytes 00, 80; ALU outputs forced to arbitrary values do not change the response.
- TIMEOUT_CYCLES=16: send A=07, then idle 16 cycles → one o_timeout pulse, state WAIT_A. Next frame 01,02,ADD → TX bytes 03, 00.
- Pulse i_rx_done during WAIT_RES → o_overrun=1 and stays 1; the response bytes are unchanged.
- Assert i_reset during WAIT_RES → all outputs at reset values, o_tx_start stays 0. A fresh frame 80,01,SRA → TX bytes C0, 00.
